// File: rtl/mem_pkg.sv
// Shared widths and FSM state encoding for the memory pipeline stage.
package mem_pkg;
    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/mem_wdog.sv
// Counts BUSY cycles; expired is high on the TIMEOUT-th consecutive enabled cycle.
// Latency: combinational expired from registered count. No backpressure.
module mem_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end
    end

    // count holds the BUSY cycles already completed, so the current one is count+1
    assign expired = enable && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: single-outstanding memory request FSM feeding MEM/WB registers.
// Latency 1 for ALU ops, >=2 for memory ops; stall holds upstream while a request is pending.
// Optional request watchdog enabled by MEM_TIMEOUT_EN (aborts after TIMEOUT BUSY cycles).
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [REG_W-1:0]  wreg_in,
    input  logic              rwrite_in,
    input  logic              mreg_in,
    input  logic              mwrite_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              valid_out,
    output logic [DATA_W-1:0] mdata_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  wreg_out,
    output logic              rwrite_out,
    output logic              mreg_out,
    output logic              err_out
);
    state_t            state, state_next;
    logic              mem_op, accept, done, abort, expired;
    logic [REG_W-1:0]  lat_wreg;
    logic              lat_rwrite, lat_mreg;

    assign mem_op = valid_in & (mreg_in | mwrite_in);

`ifdef MEM_TIMEOUT_EN
    mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (state == BUSY),
        .expired (expired)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                accept = mem_op;
                stall  = mem_op;
                if (mem_op) state_next = BUSY;
            end
            BUSY: begin
                done  = mem_ack;
                abort = ~mem_ack & expired;
                stall = ~mem_ack & ~expired;
                if (done || abort) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // reset wins over everything, including a pending request
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_wreg   <= '0;
            lat_rwrite <= 1'b0;
            lat_mreg   <= 1'b0;
            valid_out  <= 1'b0;
            mdata_out  <= '0;
            alu_out    <= '0;
            wreg_out   <= '0;
            rwrite_out <= 1'b0;
            mreg_out   <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            state     <= state_next;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            if (accept) begin
                mem_req    <= 1'b1;
                mem_we     <= mwrite_in;
                mem_addr   <= alu_in;
                mem_wdata  <= wdata_in;
                lat_wreg   <= wreg_in;
                lat_rwrite <= rwrite_in;
                lat_mreg   <= mreg_in & ~mwrite_in;
            end else if (state == IDLE) begin
                valid_out  <= valid_in;
                mdata_out  <= '0;
                alu_out    <= alu_in;
                wreg_out   <= wreg_in;
                rwrite_out <= rwrite_in;
                mreg_out   <= 1'b0;
            end
            if (done) begin
                mem_req    <= 1'b0;
                valid_out  <= 1'b1;
                mdata_out  <= mem_we ? '0 : mem_rdata;
                alu_out    <= mem_addr;
                wreg_out   <= lat_wreg;
                rwrite_out <= lat_rwrite;
                mreg_out   <= lat_mreg;
            end else if (abort) begin
                mem_req    <= 1'b0;
                valid_out  <= 1'b1;
                err_out    <= 1'b1;
                mdata_out  <= '0;
                alu_out    <= mem_addr;
                wreg_out   <= lat_wreg;
                rwrite_out <= 1'b0;
                mreg_out   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage; the driver plays upstream stage and memory.
module tb_mem_stage;
`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
    localparam bit TEN = 1'b1;
`else
    localparam int TMO = 16;
    localparam bit TEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, valid_in, rwrite_in, mreg_in, mwrite_in, mem_ack;
    logic [15:0] alu_in, wdata_in, mem_rdata;
    logic [2:0]  wreg_in;
    logic        stall, mem_req, mem_we, valid_out, rwrite_out, mreg_out, err_out;
    logic [15:0] mem_addr, mem_wdata, mdata_out, alu_out;
    logic [2:0]  wreg_out;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_in(alu_in), .wdata_in(wdata_in),
        .wreg_in(wreg_in), .rwrite_in(rwrite_in), .mreg_in(mreg_in), .mwrite_in(mwrite_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .valid_out(valid_out), .mdata_out(mdata_out), .alu_out(alu_out), .wreg_out(wreg_out),
        .rwrite_out(rwrite_out), .mreg_out(mreg_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] alu;
        logic [15:0] mdata;
        logic [2:0]  wreg;
        logic        rw;
        logic        mr;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every entry must appear exactly in its due cycle, and nothing else may.
    always @(negedge clk) begin
        if (q.size() != 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("valid_out", 32'(valid_out), 32'd1);
            chk("err_out", 32'(err_out), 32'(e.err));
            chk("rwrite_out", 32'(rwrite_out), 32'(e.rw));
            chk("mdata_out", 32'(mdata_out), 32'(e.mdata));
            if (!e.err) begin
                chk("alu_out", 32'(alu_out), 32'(e.alu));
                chk("wreg_out", 32'(wreg_out), 32'(e.wreg));
                chk("mreg_out", 32'(mreg_out), 32'(e.mr));
            end
        end else if (valid_out === 1'b1 || (!TEN && err_out !== 1'b0)) begin
            chk("unexpected_valid", 32'(valid_out), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One EX/MEM entry; d = BUSY cycle on which memory acks (0 = never).
    task automatic do_op(input logic v, input logic mr, input logic mw, input logic rw,
                         input logic [15:0] a, input logic [15:0] wd, input logic [2:0] wr,
                         input int d, input logic [15:0] rd);
        bit is_mem;
        exp_t e;
        is_mem    = v && (mr || mw);
        valid_in  = v; mreg_in = mr; mwrite_in = mw; rwrite_in = rw;
        alu_in    = a; wdata_in = wd; wreg_in = wr;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'(is_mem));
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        if (v && !is_mem) begin
            e = '{due: cyc + 1, alu: a, mdata: 16'h0, wreg: wr, rw: rw, mr: 1'b0, err: 1'b0};
            q.push_back(e);
        end
        step();
        if (is_mem) begin
            for (int k = 1; k <= 200; k++) begin
                bit ack, tmo;
                ack       = (k == d);
                tmo       = TEN && (k == TMO) && !ack;
                mem_ack   = ack;
                mem_rdata = ack ? rd : 16'($urandom);
                @(negedge clk);
                chk("busy_mem_req", 32'(mem_req), 32'd1);
                chk("busy_mem_addr", 32'(mem_addr), 32'(a));
                chk("busy_mem_we", 32'(mem_we), 32'(mw));
                chk("busy_mem_wdata", 32'(mem_wdata), 32'(wd));
                chk("busy_stall", 32'(stall), 32'(!(ack || tmo)));
                if (ack || tmo) begin
                    e = '{due: cyc + 1, alu: a, mdata: (mw || tmo) ? 16'h0 : rd, wreg: wr,
                          rw: tmo ? 1'b0 : rw, mr: mr && !mw, err: tmo};
                    q.push_back(e);
                end
                step();
                if (ack || tmo) break;
                if (k == 200) chk("busy_bound", 32'(k), 32'(d));
            end
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish by 200000");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; alu_in = '0; wdata_in = '0; wreg_in = '0;
        rwrite_in = 1'b0; mreg_in = 1'b0; mwrite_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        @(negedge clk);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err_out", 32'(err_out), 32'd0);
        step();
        rst = 1'b0;

        do_op(1, 0, 0, 1, 16'h1234, 16'h0, 3'd3, 0, 16'h0);
        do_op(0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 16'h0);
        do_op(1, 1, 0, 1, 16'h0040, 16'h0, 3'd5, 4, 16'hBEEF);
        do_op(1, 0, 1, 0, 16'h0010, 16'hA5A5, 3'd0, 1, 16'h7777);
        do_op(1, 1, 1, 1, 16'h0022, 16'h5A5A, 3'd1, 2, 16'h9999);
        do_op(1, 1, 0, 1, 16'h0050, 16'h0, 3'd6, 2, 16'hCAFE);
        do_op(1, 0, 0, 1, 16'h4321, 16'h0, 3'd2, 0, 16'h0);
        do_op(0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 16'h0);
`ifdef MEM_TIMEOUT_EN
        do_op(1, 1, 0, 1, 16'h0060, 16'h0, 3'd4, 0, 16'h0);
`else
        do_op(1, 1, 0, 1, 16'h0060, 16'h0, 3'd4, 101, 16'h1357);
`endif

        // Reset in the second BUSY cycle with a simultaneous ack
        valid_in = 1'b1; mreg_in = 1'b1; mwrite_in = 1'b0; rwrite_in = 1'b1;
        alu_in = 16'h0070; wreg_in = 3'd7; mem_ack = 1'b0;
        step();
        step();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        step();
        rst = 1'b0; mem_ack = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_valid_out", 32'(valid_out), 32'd0);
        chk("abort_mdata_out", 32'(mdata_out), 32'd0);
        chk("abort_alu_out", 32'(alu_out), 32'd0);
        chk("abort_wreg_out", 32'(wreg_out), 32'd0);
        chk("abort_rwrite_out", 32'(rwrite_out), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        step();

        for (int i = 0; i < 300; i++) begin
            logic v, mr, mw;
            v  = ($urandom_range(0, 5) != 0);
            mr = ($urandom_range(0, 2) == 0);
            mw = ($urandom_range(0, 3) == 0);
            do_op(v, mr, mw, 1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                  TEN ? $urandom_range(1, 6) : $urandom_range(1, 5), 16'($urandom));
        end

        valid_in = 1'b0;
        repeat (4) step();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 SHALL have parameter: TIMEOUT, 16, BUSY cycles without mem_ack before abort; only used with MEM_TIMEOUT_EN.
- REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
- REQ-003 SHALL have port: rst  in  1  reset; synchronous and active-high.
- REQ-004 SHALL have port: valid_in  in  1  EX/MEM entry valid.
- REQ-005 SHALL have port: alu_in  in  16  ALU result; word address for memory ops.
- REQ-006 SHALL have port: wdata_in  in  16  store data.
- REQ-007 SHALL have port: wreg_in  in  3  destination register.
- REQ-008 SHALL have port: rwrite_in  in  1  register-write enable.
- REQ-009 SHALL have port: mreg_in  in  1  load (writeback selects memory data).
- REQ-010 SHALL have port: mwrite_in  in  1  store.
- REQ-011 SHALL have port: stall  out  1  hold upstream stage and EX/MEM inputs.
- REQ-012 SHALL have ports: mem_req, mem_we  out  1  request strobe and write select.
- REQ-013 SHALL have ports: mem_addr, mem_wdata  out  16  address and store data.
- REQ-014 SHALL have ports: mem_rdata  in  16  load data; mem_ack  in  1  request complete.
- REQ-015 SHALL have ports to MEM/WB: valid_out 1, mdata_out 16, alu_out 16, wreg_out 3, rwrite_out 1, mreg_out 1, err_out 1; all registered.

Function
- REQ-016 SHALL implement FSM states IDLE and BUSY.
- REQ-017 Memory op SHALL be valid_in & (mreg_in | mwrite_in).
- REQ-018 If mreg_in and mwrite_in are both 1, the op SHALL be a store, and mreg_out SHALL be 0.
- REQ-019 In IDLE, a non-memory op SHALL appear on the outputs the next edge (latency 1), with mdata_out=0 and valid_out=1.
- REQ-020 In IDLE with no valid_in, the next edge SHALL set valid_out=0; other outputs are don't-care.
- REQ-021 In IDLE, a memory op SHALL latch address, data, we and control, and SHALL move to BUSY at the next edge.
- REQ-022 In BUSY, mem_req SHALL be 1, and mem_addr, mem_we and mem_wdata SHALL stay stable until the mem_ack cycle inclusive.
- REQ-023 stall SHALL be combinational: (IDLE & memory op) | (BUSY & ~mem_ack).
- REQ-024 In BUSY with mem_ack=0, the next edge SHALL set valid_out=0 (bubble into MEM/WB).
- REQ-025 On a BUSY cycle with mem_ack=1, the next edge SHALL set valid_out=1, mdata_out=mem_rdata (0 for a store), and the latched control outputs, and SHALL return to IDLE.
- REQ-026 Minimum memory-op latency SHALL be 2 cycles; an IDLE op in the cycle after ack SHALL be accepted normally.
- REQ-027 mem_ack outside BUSY SHALL be ignored.
- REQ-028 mem_req SHALL be 0 in IDLE; one memory op SHALL be outstanding at most.

Reset
- REQ-029 When rst=1 at an edge, the state SHALL become IDLE and all registered outputs SHALL become 0, including mem_req.
- REQ-030 rst SHALL override mem_ack in the same cycle, and a mid-operation abort SHALL produce no valid_out.
- REQ-031 stall SHALL be 0 during and immediately after reset.

Configuration
- REQ-032 Macro MEM_TIMEOUT_EN defined: the block SHALL count BUSY cycles.
- REQ-033 With MEM_TIMEOUT_EN, when the count reaches TIMEOUT without ack, the block SHALL drop mem_req, return to IDLE, and emit one entry with valid_out=1, err_out=1, rwrite_out=0, mdata_out=0.
- REQ-034 With MEM_TIMEOUT_EN, stall SHALL be 0 in that abort cycle, and the counter SHALL clear on entry to BUSY.
- REQ-035 Macro MEM_TIMEOUT_EN undefined: BUSY SHALL wait indefinitely, and err_out SHALL be constant 0 with the port retained.

Structure
- REQ-036 Shared package mem_pkg SHALL hold DATA_W=16, REG_W=3 and the state typedef {IDLE, BUSY}.
- REQ-037 Sub-module mem_wdog (timeout counter, TIMEOUT parameter, clear/enable in, expired out) SHALL be instantiated only under MEM_TIMEOUT_EN.
- REQ-038 All other logic SHALL be flat in mem_stage.

Verification
- REQ-039 ALU op alu_in=16'h1234, wreg_in=3, rwrite_in=1 -> next edge valid_out=1, alu_out=16'h1234, wreg_out=3, stall=0 throughout.
- REQ-040 Load alu_in=16'h0040, ack after 3 BUSY cycles with mem_rdata=16'hBEEF -> stall high 4 cycles, valid_out low 3 edges, then valid_out=1, mdata_out=16'hBEEF, mreg_out=1.
- REQ-041 Store alu_in=16'h0010, wdata_in=16'hA5A5, ack on first BUSY cycle -> mem_we=1, mem_wdata=16'hA5A5 stable, result 2 cycles after accept, mdata_out=0.
- REQ-042 rst=1 in second BUSY cycle with mem_ack=1 -> IDLE, mem_req=0, all outputs 0, no valid_out.
- REQ-043 MEM_TIMEOUT_EN, TIMEOUT=4, load never acked -> mem_req for 4 cycles, then valid_out=1, err_out=1, rwrite_out=0; without macro, stall held 100 cycles.
- REQ-044 Back-to-back load then ALU op -> the ALU op is accepted the cycle after ack, and outputs are ordered load then ALU.
